// File: rtl/nrzi_bit_stuffer.sv
// USB serial TX line coder: pulls bits from the byte PISO, inserts a stuff 0
// after STUFF_LEN consecutive 1s, NRZI-encodes onto dp/dm, then appends EOP
// (SE0 x EOP_SE0_BITS, J x 1) before releasing the pads.
module nrzi_bit_stuffer #(
    parameter int STUFF_LEN    = 6,
    parameter int EOP_SE0_BITS = 2,
    parameter int LOW_SPEED    = 0
) (
    input  logic clk,
    input  logic nRST,
    input  logic bit_tick,
    input  logic tx_en,
    input  logic src_busy,
    input  logic bit_in,
    output logic shift_req,
    output logic dp,
    output logic dm,
    output logic tx_oe,
    output logic stuff_active,
    output logic eop_done
);

    localparam int CNT_W = $clog2(STUFF_LEN + 1);
    localparam int SE0_W = $clog2(EOP_SE0_BITS + 1);

    localparam logic [1:0]       LINE_J    = (LOW_SPEED != 0) ? 2'b01 : 2'b10;
    localparam logic [1:0]       LINE_SE0  = 2'b00;
    localparam logic [CNT_W-1:0] ONES_MAX  = CNT_W'(STUFF_LEN);
    localparam logic [SE0_W-1:0] SE0_LAST  = SE0_W'(EOP_SE0_BITS);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        EOP_SE0,
        EOP_J
    } state_t;

    state_t           state, state_nxt;
    logic [1:0]       line, line_nxt;
    logic             tx_oe_nxt;
    logic             shift_req_nxt;
    logic             stuff_nxt;
    logic             eop_nxt;
    logic [CNT_W-1:0] ones_cnt, ones_cnt_nxt;
    logic [SE0_W-1:0] se0_cnt, se0_cnt_nxt;
    logic             pre_valid, pre_valid_nxt;
    logic             pre_bit;
    // shift_req delayed one clock: the PISO presents the fetched bit one clk after the request
    logic             fetch_p1;

    assign dp = line[1];
    assign dm = line[0];

    // Next-state and registered-output decode; only bit_tick edges advance the line
    always_comb begin
        state_nxt     = state;
        line_nxt      = line;
        tx_oe_nxt     = tx_oe;
        shift_req_nxt = 1'b0;
        stuff_nxt     = 1'b0;
        eop_nxt       = 1'b0;
        ones_cnt_nxt  = ones_cnt;
        se0_cnt_nxt   = se0_cnt;
        pre_valid_nxt = pre_valid;

        if (fetch_p1) begin
            pre_valid_nxt = 1'b1;
        end

        if (bit_tick) begin
            case (state)
                IDLE: begin
                    line_nxt  = LINE_J;
                    tx_oe_nxt = 1'b0;
                    if (tx_en && src_busy) begin
                        shift_req_nxt = 1'b1;
                        tx_oe_nxt     = 1'b1;
                        state_nxt     = ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (ones_cnt == ONES_MAX) begin
                        // Stuff bit takes priority, even over end-of-data; pre_bit waits
                        line_nxt     = ~line;
                        ones_cnt_nxt = '0;
                        stuff_nxt    = 1'b1;
                    end else if (pre_valid) begin
                        if (pre_bit) begin
                            ones_cnt_nxt = ones_cnt + CNT_W'(1);
                        end else begin
                            line_nxt     = ~line;
                            ones_cnt_nxt = '0;
                        end
                        if (tx_en && src_busy) begin
                            shift_req_nxt = 1'b1;
                        end else begin
                            pre_valid_nxt = 1'b0;
                        end
                    end else begin
                        line_nxt    = LINE_SE0;
                        se0_cnt_nxt = SE0_W'(1);
                        state_nxt   = EOP_SE0;
                    end
                end
                EOP_SE0: begin
                    if (se0_cnt >= SE0_LAST) begin
                        line_nxt  = LINE_J;
                        state_nxt = EOP_J;
                    end else begin
                        se0_cnt_nxt = se0_cnt + SE0_W'(1);
                    end
                end
                EOP_J: begin
                    tx_oe_nxt    = 1'b0;
                    eop_nxt      = 1'b1;
                    ones_cnt_nxt = '0;
                    state_nxt    = IDLE;
                end
                default: begin
                    line_nxt  = LINE_J;
                    tx_oe_nxt = 1'b0;
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Control and line registers; reset drops the packet at once with the bus back at J
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state        <= IDLE;
            line         <= LINE_J;
            tx_oe        <= 1'b0;
            shift_req    <= 1'b0;
            stuff_active <= 1'b0;
            eop_done     <= 1'b0;
            ones_cnt     <= '0;
            se0_cnt      <= '0;
            pre_valid    <= 1'b0;
            fetch_p1     <= 1'b0;
        end else begin
            state        <= state_nxt;
            line         <= line_nxt;
            tx_oe        <= tx_oe_nxt;
            shift_req    <= shift_req_nxt;
            stuff_active <= stuff_nxt;
            eop_done     <= eop_nxt;
            ones_cnt     <= ones_cnt_nxt;
            se0_cnt      <= se0_cnt_nxt;
            pre_valid    <= pre_valid_nxt;
            fetch_p1     <= shift_req;
        end
    end

    // Prefetched data bit; qualified by pre_valid so it needs no reset
    always_ff @(posedge clk) begin
        if (fetch_p1) begin
            pre_bit <= bit_in;
        end
    end

endmodule

// File: tb/tb_nrzi_bit_stuffer.sv
// Directed bench for nrzi_bit_stuffer: table of byte streams with hand-derived
// per-tick line symbols, plus a mid-packet reset sequence. A full-speed and a
// low-speed instance run side by side on the same stimulus.
module tb_nrzi_bit_stuffer;

    logic clk      = 1'b0;
    logic nRST     = 1'b0;
    logic bit_tick = 1'b0;
    logic tx_en    = 1'b0;
    logic bit_in   = 1'b0;
    logic src_busy;

    logic shift_req, dp, dm, tx_oe, stuff_active, eop_done;
    logic ls_shift_req, ls_dp, ls_dm, ls_tx_oe, ls_stuff, ls_eop;

    int total = 0;
    int bad   = 0;

    // Source model: MSB-first shift register, presents the shifted bit one clk after shift_req
    logic [15:0] src_data = '0;
    int          src_len  = 0;
    int          idx      = 0;
    logic        load     = 1'b0;

    assign src_busy = (idx < src_len);

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load) begin
            idx <= 0;
        end else if (shift_req && (idx < src_len)) begin
            bit_in <= src_data[src_len-1-idx];
            idx    <= idx + 1;
        end
    end

    nrzi_bit_stuffer #(.STUFF_LEN(6), .EOP_SE0_BITS(2), .LOW_SPEED(0)) dut (
        .clk(clk), .nRST(nRST), .bit_tick(bit_tick), .tx_en(tx_en),
        .src_busy(src_busy), .bit_in(bit_in), .shift_req(shift_req),
        .dp(dp), .dm(dm), .tx_oe(tx_oe), .stuff_active(stuff_active),
        .eop_done(eop_done)
    );

    nrzi_bit_stuffer #(.STUFF_LEN(6), .EOP_SE0_BITS(2), .LOW_SPEED(1)) dut_ls (
        .clk(clk), .nRST(nRST), .bit_tick(bit_tick), .tx_en(tx_en),
        .src_busy(src_busy), .bit_in(bit_in), .shift_req(ls_shift_req),
        .dp(ls_dp), .dm(ls_dm), .tx_oe(ls_tx_oe), .stuff_active(ls_stuff),
        .eop_done(ls_eop)
    );

    typedef struct {
        logic [15:0]     data;
        int              nbits;
        int              drop_at;   // tick before which tx_en falls, -1 = never
        logic [8*24-1:0] exp;       // per-tick line: J, K or 0 (SE0), from tick 0
        int              exp_len;   // eop_done expected on tick exp_len
        int              stuff_at;  // tick carrying the stuff bit, -1 = none
        int              n_shift;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [1:0] sym(input logic [7:0] c, input bit ls);
        if (c == "J") return ls ? 2'b01 : 2'b10;
        if (c == "K") return ls ? 2'b10 : 2'b01;
        return 2'b00;
    endfunction

    task automatic tick_edge();
        @(negedge clk);
        bit_tick = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic tick_gap();
        @(negedge clk);
        bit_tick = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic load_src(input logic [15:0] d, input int n);
        @(negedge clk);
        src_data = d;
        src_len  = n;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int tag);
        int nsh;
        logic [7:0] c;
        nsh = 0;
        load_src(v.data, v.nbits);
        tx_en = 1'b1;
        for (int t = 0; t <= v.exp_len; t++) begin
            if (t == v.drop_at) tx_en = 1'b0;
            tick_edge();
            if (shift_req) nsh++;
            if (t < v.exp_len) begin
                c = v.exp[8*(v.exp_len-1-t) +: 8];
                chk($sformatf("v%0d_line_t%0d", tag, t), {30'd0, dp, dm}, {30'd0, sym(c, 1'b0)});
                chk($sformatf("v%0d_ls_line_t%0d", tag, t), {30'd0, ls_dp, ls_dm}, {30'd0, sym(c, 1'b1)});
                chk($sformatf("v%0d_oe_t%0d", tag, t), {31'd0, tx_oe}, 32'd1);
                chk($sformatf("v%0d_stuff_t%0d", tag, t), {31'd0, stuff_active}, {31'd0, t == v.stuff_at});
                chk($sformatf("v%0d_eop_early_t%0d", tag, t), {31'd0, eop_done}, 32'd0);
                if (t == v.stuff_at) begin
                    chk($sformatf("v%0d_noshift_on_stuff", tag), {31'd0, shift_req}, 32'd0);
                    chk($sformatf("v%0d_ls_stuff", tag), {31'd0, ls_stuff}, 32'd1);
                end
            end else begin
                chk($sformatf("v%0d_eop_done", tag), {31'd0, eop_done}, 32'd1);
                chk($sformatf("v%0d_ls_eop_done", tag), {31'd0, ls_eop}, 32'd1);
                chk($sformatf("v%0d_oe_release", tag), {31'd0, tx_oe}, 32'd0);
                chk($sformatf("v%0d_ls_oe_release", tag), {31'd0, ls_tx_oe}, 32'd0);
                chk($sformatf("v%0d_idle_line", tag), {30'd0, dp, dm}, 32'd2);
            end
            tick_gap();
        end
        chk($sformatf("v%0d_shift_count", tag), nsh, v.n_shift);
        tx_en = 1'b0;
    endtask

    initial begin
        // 0x00: eight toggles from J, then SE0 SE0 J
        vecs[0] = '{16'h0000, 8,  -1, "JKJKJKJKJ00J",          12, -1, 8};
        // 0xFF 0x00: six holds, stuff toggle, last two 1s, eight toggles, EOP
        vecs[1] = '{16'hFF00, 16, -1, "JJJJJJJKKKJKJKJKJK00J", 21,  7, 16};
        // 0x3F: trailing six 1s get their stuff bit before EOP
        vecs[2] = '{16'h003F, 8,  -1, "JKJJJJJJJK00J",         13,  9, 8};
        // 0x00 with tx_en dropped before tick 4: one more bit, then EOP
        vecs[3] = '{16'h0000, 8,   4, "JKJKJ00J",               8, -1, 4};

        #23;
        chk("rst_line",      {30'd0, dp, dm}, 32'd2);
        chk("rst_ls_line",   {30'd0, ls_dp, ls_dm}, 32'd1);
        chk("rst_oe",        {31'd0, tx_oe}, 32'd0);
        chk("rst_shift_req", {31'd0, shift_req}, 32'd0);
        chk("rst_stuff",     {31'd0, stuff_active}, 32'd0);
        chk("rst_eop",       {31'd0, eop_done}, 32'd0);
        @(negedge clk);
        nRST = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            run_vec(vecs[i], i);
            repeat (4) @(negedge clk);
        end

        // Mid-packet reset: 0x7F leaves the line at K with a partial run of 1s
        load_src(16'h007F, 8);
        tx_en = 1'b1;
        for (int t = 0; t < 6; t++) begin
            tick_edge();
            tick_gap();
        end
        chk("pre_rst_line_k", {30'd0, dp, dm}, 32'd1);
        @(negedge clk);
        #2 nRST = 1'b0;
        #1;
        chk("midrst_oe",      {31'd0, tx_oe}, 32'd0);
        chk("midrst_line",    {30'd0, dp, dm}, 32'd2);
        chk("midrst_ls_line", {30'd0, ls_dp, ls_dm}, 32'd1);
        chk("midrst_eop",     {31'd0, eop_done}, 32'd0);
        @(negedge clk);
        nRST  = 1'b1;
        tx_en = 1'b0;
        load_src(16'h0000, 0);
        for (int t = 0; t < 6; t++) begin
            tick_edge();
            chk($sformatf("postrst_eop_t%0d", t), {31'd0, eop_done}, 32'd0);
            chk($sformatf("postrst_oe_t%0d", t), {31'd0, tx_oe}, 32'd0);
            chk($sformatf("postrst_line_t%0d", t), {30'd0, dp, dm}, 32'd2);
            tick_gap();
        end
        // Clean packet after reset; a stale run count would move the stuff bit
        run_vec(vecs[1], 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
